// File: rtl/riscv_mem_pkg.sv
// Shared encodings, port ids, arbiter state enum and byte-lane helper for the
// data-memory port arbiter.
package riscv_mem_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCK    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Lane-encoded view of one port's request, ready for the grant mux
    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        misalign;
    } lane_req_t;

    // Byte offset 0 maps to the most-significant lane
    function automatic logic [3:0] be_from_offset(input logic [1:0] offset);
        return 4'b1000 >> offset;
    endfunction

endpackage

// File: rtl/mem_lane_encoder.sv
// Per-port byte-lane encoder: byte enables, replicated store data and
// misaligned-word detection.
module mem_lane_encoder
    import riscv_mem_pkg::*;
(
    input  logic        we,
    input  logic        size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output lane_req_t   lane
);

    always_comb begin
        lane.misalign = (size == SIZE_WORD) && (offset != 2'b00);
        lane.be       = 4'b1111;
        lane.wdata    = wdata;
        if (size == SIZE_BYTE) begin
            lane.wdata = {4{wdata[7:0]}};
            if (we) begin
                lane.be = be_from_offset(offset);
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous data memory between the
// core load/store port and a debug/loader port, with a bounded debug burst lock.
module dmem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_size,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_err,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_size,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_err,
    output logic              dbg_rvalid,
    output logic [31:0]       dbg_rdata,
    input  logic              dbg_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

    lane_req_t        core_lane;
    lane_req_t        dbg_lane;
    logic             core_ok;
    logic             dbg_ok;
    arb_state_e       state_q, state_d;
    logic             rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             tag_q, tag_d;
    logic             unused_addr_hi;

    mem_lane_encoder u_core_enc (
        .we     (core_we),
        .size   (core_size),
        .offset (core_addr[1:0]),
        .wdata  (core_wdata),
        .lane   (core_lane)
    );

    mem_lane_encoder u_dbg_enc (
        .we     (dbg_we),
        .size   (dbg_size),
        .offset (dbg_addr[1:0]),
        .wdata  (dbg_wdata),
        .lane   (dbg_lane)
    );

    // Addresses beyond the memory wrap; the high bits are intentionally ignored
    assign unused_addr_hi = ^{core_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W+2]};

    assign core_ok = core_req & ~core_lane.misalign;
    assign dbg_ok  = dbg_req & ~dbg_lane.misalign;

    // Arbitration, errors and lock bookkeeping
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        core_err = 1'b0;
        dbg_err  = dbg_req & dbg_lane.misalign;
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;

        case (state_q)
            ARB: begin
                core_err = core_req & core_lane.misalign;
                if (core_ok && dbg_ok) begin
                    core_gnt = (rr_q == PORT_DBG);
                    dbg_gnt  = (rr_q == PORT_CORE);
                end else begin
                    core_gnt = core_ok;
                    dbg_gnt  = dbg_ok;
                end
                if (dbg_gnt && dbg_lock) begin
                    state_d = LOCK;
                    cnt_d   = CNT_W'(1);
                end
            end
            LOCK: begin
                dbg_gnt = dbg_ok;
                cnt_d   = cnt_q + CNT_W'(1);
                if (!dbg_lock) begin
                    state_d = ARB;
                end else if (32'(cnt_q) + 32'd1 >= LOCK_MAX) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                core_err = core_req & core_lane.misalign;
                core_gnt = core_ok;
                dbg_gnt  = dbg_ok & ~core_req;
                state_d  = ARB;
            end
            default: begin
                state_d = ARB;
            end
        endcase

        if (core_gnt) begin
            rr_d = PORT_CORE;
        end else if (dbg_gnt) begin
            rr_d = PORT_DBG;
        end

        // Outputs read as idle for as long as reset is held
        if (reset) begin
            core_gnt = 1'b0;
            dbg_gnt  = 1'b0;
            core_err = 1'b0;
            dbg_err  = 1'b0;
        end
    end

    // Memory mux from the granted port and read-data return to its owner
    always_comb begin
        mem_en    = core_gnt | dbg_gnt;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_be    = core_lane.be;
            mem_addr  = core_addr[ADDR_W+1:2];
            mem_wdata = core_lane.wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_be    = dbg_lane.be;
            mem_addr  = dbg_addr[ADDR_W+1:2];
            mem_wdata = dbg_lane.wdata;
        end

        pend_d = mem_en & ~mem_we;
        tag_d  = dbg_gnt ? PORT_DBG : PORT_CORE;

        core_rvalid = pend_q & (tag_q == PORT_CORE);
        dbg_rvalid  = pend_q & (tag_q == PORT_DBG);
        core_rdata  = core_rvalid ? mem_rdata : 32'h0;
        dbg_rdata   = dbg_rvalid ? mem_rdata : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
            rr_q    <= PORT_DBG;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tag_q   <= PORT_CORE;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tag_q   <= tag_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed vector table, multi-cycle
// lock/reset sequences and random traffic against a behavioural model.
module tb_dmem_port_arbiter;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned LOCK_MAX = 16;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic        creq;
        logic        cwe;
        logic        csize;
        logic [31:0] caddr;
        logic [31:0] cwd;
        logic        dreq;
        logic        dwe;
        logic        dsize;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic        dlock;
    } in_t;

    typedef struct packed {
        logic        cg;
        logic        ce;
        logic        dg;
        logic        de;
        logic        en;
        logic        we;
        logic [3:0]  be;
        logic [4:0]  ma;
        logic [31:0] mwd;
        logic        crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t e;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              core_req, core_we, core_size;
    logic [31:0]       core_addr, core_wdata;
    logic              core_gnt, core_err, core_rvalid;
    logic [31:0]       core_rdata;
    logic              dbg_req, dbg_we, dbg_size;
    logic [31:0]       dbg_addr, dbg_wdata;
    logic              dbg_gnt, dbg_err, dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_lock;
    logic              mem_en, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_last;       // last granted port: 0 core, 1 dbg
    int          m_lock_run;   // cycles of debug ownership under lock, 0 = unlocked
    bit          m_release;
    bit          m_pend;
    int          m_pend_owner;
    logic [31:0] m_pend_data;
    logic [31:0] ref_mem [32];
    logic [31:0] tb_mem  [32];

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_size(core_size),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_err(core_err), .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_err(dbg_err), .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory behind the arbiter
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (mem_be[i]) tb_mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end else begin
                mem_rdata <= tb_mem[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input exp_t got, input exp_t e, input string tag);
        chk({tag, ".core_gnt"},    32'(got.cg),  32'(e.cg));
        chk({tag, ".core_err"},    32'(got.ce),  32'(e.ce));
        chk({tag, ".dbg_gnt"},     32'(got.dg),  32'(e.dg));
        chk({tag, ".dbg_err"},     32'(got.de),  32'(e.de));
        chk({tag, ".mem_en"},      32'(got.en),  32'(e.en));
        chk({tag, ".mem_we"},      32'(got.we),  32'(e.we));
        chk({tag, ".mem_be"},      32'(got.be),  32'(e.be));
        chk({tag, ".mem_addr"},    32'(got.ma),  32'(e.ma));
        chk({tag, ".mem_wdata"},   got.mwd,      e.mwd);
        chk({tag, ".core_rvalid"}, 32'(got.crv), 32'(e.crv));
        chk({tag, ".core_rdata"},  got.crd,      e.crd);
        chk({tag, ".dbg_rvalid"},  32'(got.drv), 32'(e.drv));
        chk({tag, ".dbg_rdata"},   got.drd,      e.drd);
    endtask

    task automatic drive(input in_t v);
        core_req = v.creq;  core_we = v.cwe;  core_size = v.csize;
        core_addr = v.caddr; core_wdata = v.cwd;
        dbg_req = v.dreq;   dbg_we = v.dwe;   dbg_size = v.dsize;
        dbg_addr = v.daddr; dbg_wdata = v.dwd; dbg_lock = v.dlock;
    endtask

    task automatic sample(output exp_t got);
        got.cg = core_gnt; got.ce = core_err; got.dg = dbg_gnt; got.de = dbg_err;
        got.en = mem_en; got.we = mem_we; got.be = mem_be; got.ma = mem_addr;
        got.mwd = mem_wdata; got.crv = core_rvalid; got.crd = core_rdata;
        got.drv = dbg_rvalid; got.drd = dbg_rdata;
    endtask

    task automatic m_reset();
        m_last = 1; m_lock_run = 0; m_release = 0; m_pend = 0;
        m_pend_owner = 0; m_pend_data = 32'h0;
    endtask

    // One clock cycle: drive, predict from the model, compare, advance the model
    task automatic step(input in_t v, input string tag, output exp_t got);
        exp_t        e;
        logic        cmis, dmis, c_ok, d_ok, locked, wc, wd, sz, we;
        logic [31:0] a, wdv;
        int          off, w;
        @(posedge clk); #1;
        drive(v);
        cmis = v.creq && v.csize && (v.caddr % 4 != 0);
        dmis = v.dreq && v.dsize && (v.daddr % 4 != 0);
        c_ok = v.creq && !cmis;
        d_ok = v.dreq && !dmis;
        locked = (m_lock_run != 0);
        wc = 1'b0; wd = 1'b0;
        if (locked) begin
            wd = d_ok;
        end else if (m_release) begin
            wc = c_ok;
            wd = d_ok && !v.creq;
        end else if (c_ok && d_ok) begin
            wc = (m_last == 1);
            wd = (m_last == 0);
        end else begin
            wc = c_ok;
            wd = d_ok;
        end
        e = '0;
        e.cg = wc; e.dg = wd;
        e.ce = cmis && !locked;
        e.de = dmis;
        if (wc || wd) begin
            we  = wc ? v.cwe : v.dwe;
            sz  = wc ? v.csize : v.dsize;
            a   = wc ? v.caddr : v.daddr;
            wdv = wc ? v.cwd : v.dwd;
            off = int'(a % 4);
            e.en  = 1'b1;
            e.we  = we;
            e.be  = (we && !sz) ? 4'(8 >> off) : 4'hF;
            e.ma  = 5'((a / 4) % 32);
            e.mwd = sz ? wdv : (wdv % 256) * 32'h0101_0101;
        end
        if (m_pend) begin
            if (m_pend_owner == 0) begin e.crv = 1'b1; e.crd = m_pend_data; end
            else                   begin e.drv = 1'b1; e.drd = m_pend_data; end
        end
        @(negedge clk);
        sample(got);
        cmp_all(got, e, tag);
        if (wc) m_last = 0;
        if (wd) m_last = 1;
        if (locked) begin
            if (!v.dlock) m_lock_run = 0;
            else begin
                m_lock_run++;
                if (m_lock_run >= LOCK_MAX) begin m_lock_run = 0; m_release = 1; end
            end
        end else if (m_release) begin
            m_release = 0;
        end else if (wd && v.dlock) begin
            m_lock_run = 1;
        end
        w = int'(e.ma);
        m_pend = e.en && !e.we;
        m_pend_owner = wd ? 1 : 0;
        if (m_pend) m_pend_data = ref_mem[w];
        if (e.en && e.we) begin
            for (int i = 0; i < 4; i++) if (e.be[i]) ref_mem[w][8*i +: 8] = e.mwd[8*i +: 8];
        end
    endtask

    // Assert reset mid-cycle and require every output to read zero
    task automatic apply_reset(input logic with_reqs, input string tag);
        in_t  v;
        exp_t got;
        @(posedge clk); #1;
        reset = 1'b1;
        v = '0;
        v.creq = with_reqs; v.dreq = with_reqs; v.csize = H; v.dsize = H;
        v.daddr = 32'h10; v.dlock = with_reqs;
        drive(v);
        @(negedge clk);
        sample(got);
        cmp_all(got, exp_t'('0), tag);
        m_reset();
        @(posedge clk); #1;
        drive(in_t'('0));
        reset = 1'b0;
    endtask

    function automatic in_t rand_in(input bit lock_heavy);
        in_t v;
        v.creq  = ($urandom_range(0, 3) != 0);
        v.cwe   = 1'($urandom_range(0, 1));
        v.csize = 1'($urandom_range(0, 1));
        v.caddr = ($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 9);
        if (!v.csize || $urandom_range(0, 7) == 0) v.caddr = v.caddr | $urandom_range(0, 3);
        v.cwd   = $urandom;
        v.dreq  = ($urandom_range(0, 3) != 0);
        v.dwe   = 1'($urandom_range(0, 1));
        v.dsize = 1'($urandom_range(0, 1));
        v.daddr = ($urandom_range(0, 31) << 2) | ($urandom_range(0, 1) << 12);
        if (!v.dsize || $urandom_range(0, 7) == 0) v.daddr = v.daddr | $urandom_range(0, 3);
        v.dwd   = $urandom;
        v.dlock = lock_heavy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
        return v;
    endfunction

    vec_t tv [14];
    int   gs [22];
    int   exp_gs;

    initial begin
        exp_t got;
        in_t  v;
        in_t  both_rd;
        for (int i = 0; i < 32; i++) begin tb_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
        mem_rdata = 32'h0;
        reset = 1'b1;
        drive(in_t'('0));
        m_reset();

        //            creq cwe csize caddr        cwd            dreq dwe dsize daddr     dwd           dlock
        //            cg ce dg de en we be       ma     mwd           crv crd            drv drd
        tv[0]  = '{'{H,H,H,32'h08,32'hDEADBEEF, L,L,L,32'h00,32'h0,L},
                   '{H,L,L,L,H,H,4'b1111,5'd2,32'hDEADBEEF, L,32'h0,L,32'h0}};
        tv[1]  = '{'{H,L,H,32'h08,32'h0, L,L,L,32'h00,32'h0,L},
                   '{H,L,L,L,H,L,4'b1111,5'd2,32'h0, L,32'h0,L,32'h0}};
        tv[2]  = '{'{H,H,L,32'h0D,32'h000000A5, L,L,L,32'h00,32'h0,L},
                   '{H,L,L,L,H,H,4'b0100,5'd3,32'hA5A5A5A5, H,32'hDEADBEEF,L,32'h0}};
        tv[3]  = '{'{H,L,H,32'h06,32'h0, L,L,L,32'h00,32'h0,L},
                   '{L,H,L,L,L,L,4'b0000,5'd0,32'h0, L,32'h0,L,32'h0}};
        tv[4]  = '{'{L,L,L,32'h00,32'h0, H,H,H,32'h10,32'h12345678,L},
                   '{L,L,H,L,H,H,4'b1111,5'd4,32'h12345678, L,32'h0,L,32'h0}};
        tv[5]  = '{'{H,L,H,32'h0C,32'h0, H,L,H,32'h10,32'h0,L},
                   '{H,L,L,L,H,L,4'b1111,5'd3,32'h0, L,32'h0,L,32'h0}};
        tv[6]  = '{'{H,L,H,32'h0C,32'h0, H,L,H,32'h10,32'h0,L},
                   '{L,L,H,L,H,L,4'b1111,5'd4,32'h0, H,32'h00A50000,L,32'h0}};
        tv[7]  = '{'{L,L,L,32'h00,32'h0, L,L,L,32'h00,32'h0,L},
                   '{L,L,L,L,L,L,4'b0000,5'd0,32'h0, L,32'h0,H,32'h12345678}};
        tv[8]  = '{'{H,L,H,32'h06,32'h0, H,H,L,32'h03,32'h0000005A,L},
                   '{L,H,H,L,H,H,4'b0001,5'd0,32'h5A5A5A5A, L,32'h0,L,32'h0}};
        tv[9]  = '{'{H,H,H,32'h20,32'hCAFEF00D, H,L,H,32'h22,32'h0,L},
                   '{H,L,L,H,H,H,4'b1111,5'd8,32'hCAFEF00D, L,32'h0,L,32'h0}};
        tv[10] = '{'{H,L,H,32'h88,32'h0, L,L,L,32'h00,32'h0,L},
                   '{H,L,L,L,H,L,4'b1111,5'd2,32'h0, L,32'h0,L,32'h0}};
        tv[11] = '{'{L,L,L,32'h00,32'h0, L,L,L,32'h00,32'h0,L},
                   '{L,L,L,L,L,L,4'b0000,5'd0,32'h0, H,32'hDEADBEEF,L,32'h0}};
        tv[12] = '{'{L,L,L,32'h00,32'h0, H,L,H,32'h00,32'h0,L},
                   '{L,L,H,L,H,L,4'b1111,5'd0,32'h0, L,32'h0,L,32'h0}};
        tv[13] = '{'{L,L,L,32'h00,32'h0, L,L,L,32'h00,32'h0,L},
                   '{L,L,L,L,L,L,4'b0000,5'd0,32'h0, L,32'h0,H,32'h0000005A}};

        // Reset state, with both ports requesting while reset is held
        apply_reset(H, "reset");

        for (int i = 0; i < 14; i++) begin
            step(tv[i].in, $sformatf("vec%0d", i), got);
            cmp_all(got, tv[i].e, $sformatf("tbl%0d", i));
        end

        // Both ports loading every cycle: strict alternation starting with core
        apply_reset(L, "rst_alt");
        both_rd = '0;
        both_rd.creq = H; both_rd.csize = H; both_rd.caddr = 32'h08;
        both_rd.dreq = H; both_rd.dsize = H; both_rd.daddr = 32'h10;
        for (int i = 0; i < 6; i++) begin
            step(both_rd, $sformatf("alt%0d", i), got);
            chk($sformatf("alt%0d.order", i), 32'(got.cg), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Debug lock held 20 cycles under full contention
        apply_reset(L, "rst_lock");
        for (int i = 0; i < 22; i++) begin
            v = both_rd;
            v.dlock = (i < 20);
            step(v, $sformatf("lock%0d", i), got);
            gs[i] = got.dg ? 1 : (got.cg ? 0 : 2);
        end
        for (int i = 0; i < 22; i++) begin
            exp_gs = (i == 0 || i == 17 || i == 21) ? 0 : 1;
            chk($sformatf("lock_seq%0d", i), 32'(gs[i]), 32'(exp_gs));
        end

        // Reset landing the cycle after a debug read grant drops the return
        v = '0;
        v.dreq = H; v.dsize = H; v.daddr = 32'h10;
        step(v, "pre_rst", got);
        apply_reset(H, "rst_mid");
        step(both_rd, "post_rst", got);
        chk("post_rst.core_first", 32'(got.cg), 32'd1);

        // Random traffic against the model, with a reset part way through
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) apply_reset(H, "rst_rand");
            step(rand_in(i >= 1000 && i < 2500), "rand", got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
